// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state type, default constants and the single-step helper for lfsr_stream.
package lfsr_pkg;
    typedef enum logic {S_WARM, S_RUN} lfsr_state_e;
    localparam int LFSR_MAX_W = 64;
    localparam logic [31:0] LFSR_TAPS32 = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED32 = 32'h1ACE_B00C;
    // Operates on a zero-extended state; callers truncate the result back to their width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] r,
                                                        input logic [LFSR_MAX_W-1:0] taps);
        return {r[LFSR_MAX_W-2:0], ^(r & taps)};
    endfunction
endpackage

// File: rtl/lfsr_advance.sv
// lfsr_advance: combinational STEPS-fold LFSR advance with seed override and zero-state guard.
module lfsr_advance
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS32),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED32),
    parameter int STEPS = 1
) (
    input  logic [WIDTH-1:0] r,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] nxt,
    output logic             zero_hit
);
    logic [LFSR_MAX_W-1:0] s;
    logic [WIDTH-1:0] raw;
    always_comb begin
        s = LFSR_MAX_W'(r);
        for (int i = 0; i < STEPS; i++)
            s = LFSR_MAX_W'(WIDTH'(lfsr_step(s, LFSR_MAX_W'(TAPS))));
        raw = load ? load_val : WIDTH'(s);
        zero_hit = raw == '0;
        nxt = zero_hit ? SEED : raw;
    end
endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: Fibonacci LFSR word source with valid/ready stream, reseeding, warm-up discard and lockup recovery.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS32),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED32),
    parameter int STEPS = 1,
    parameter int WARMUP = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic [CNT_W-1:0] beat_cnt
);
    localparam int WC_W = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
    lfsr_state_e state, state_nxt;
    logic [WC_W-1:0] warm_cnt, warm_nxt;
    logic [WIDTH-1:0] r, r_nxt, adv_val;
    logic [CNT_W-1:0] beat_nxt;
    logic lockup_nxt, adv_hit, adv_en, hs;
    lfsr_advance #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .STEPS(STEPS)) u_adv (
        .r(r),
        .load(seed_load),
        .load_val(seed_in),
        .nxt(adv_val),
        .zero_hit(adv_hit)
    );
    assign out_valid = state == S_RUN;
    assign out_data = r;
    assign hs = out_valid & out_ready;
    // In RUN, stream mode advances only on acceptance; free-run ignores ready.
    assign adv_en = state == S_WARM ? warm_cnt != '0 : (mode | out_ready);
    always_comb begin
        state_nxt = seed_load ? S_WARM : (state == S_WARM && warm_cnt == '0) ? S_RUN : state;
        warm_nxt = seed_load ? WC_W'(WARMUP) : (state == S_WARM && warm_cnt != '0) ? warm_cnt - WC_W'(1) : warm_cnt;
        r_nxt = (seed_load | adv_en) ? adv_val : r;
        lockup_nxt = seed_load ? adv_hit : lockup | (adv_en & adv_hit);
        beat_nxt = hs ? beat_cnt + CNT_W'(1) : beat_cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WARM;
            warm_cnt <= WC_W'(WARMUP);
            r <= SEED;
            lockup <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            warm_cnt <= warm_nxt;
            r <= r_nxt;
            lockup <= lockup_nxt;
            beat_cnt <= beat_nxt;
        end
    end
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed checks of lfsr_stream with default, STEPS=4/WARMUP=0 and CNT_W=4 instances.
module tb_lfsr_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode = 1'b0;
    logic seed_load = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] seed_in = '0;
    logic v0, v1, v2, l0, l1, l2;
    logic [31:0] d0, d1, d2, b0, b1;
    logic [3:0] b2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_stream u0 (.clk(clk), .rst_n(rst_n), .mode(mode), .seed_load(seed_load), .seed_in(seed_in),
                    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .lockup(l0), .beat_cnt(b0));
    lfsr_stream #(.STEPS(4), .WARMUP(0)) u1 (.clk(clk), .rst_n(rst_n), .mode(mode), .seed_load(seed_load),
                    .seed_in(seed_in), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .lockup(l1),
                    .beat_cnt(b1));
    lfsr_stream #(.CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .mode(mode), .seed_load(seed_load), .seed_in(seed_in),
                    .out_valid(v2), .out_ready(out_ready), .out_data(d2), .lockup(l2), .beat_cnt(b2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hand-derived sequence from seed 1ACEB00C, taps 8020_0003 (r4 = four steps, etc.)
    localparam logic [31:0] SEED = 32'h1ACE_B00C;
    localparam logic [31:0] R4 = 32'hACEB_00C3;
    localparam logic [31:0] R5 = 32'h59D6_0186;
    localparam logic [31:0] R6 = 32'hB3AC_030D;
    localparam logic [31:0] R7 = 32'h6758_061B;
    localparam logic [31:0] R8 = 32'hCEB0_0C36;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(v0), 64'(1'b0));
        check("rst_data", 64'(d0), 64'(SEED));
        check("rst_lockup", 64'(l0), 64'(1'b0));
        check("rst_beat", 64'(b0), 64'(0));
        rst_n = 1'b1;
        tick;
        check("u1_first_valid", 64'(v1), 64'(1'b1));
        check("u1_first_data", 64'(d1), 64'(SEED));
        repeat (3) tick;
        check("warm_valid_low", 64'(v0), 64'(1'b0));
        tick;
        check("first_valid", 64'(v0), 64'(1'b1));
        check("first_word", 64'(d0), 64'(R4));
        repeat (10) tick;
        check("stall_data", 64'(d0), 64'(R4));
        check("stall_beat", 64'(b0), 64'(0));
        check("u1_stall_data", 64'(d1), 64'(SEED));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("accept1_data", 64'(d0), 64'(R5));
        check("accept1_beat", 64'(b0), 64'(1));
        check("u1_step4_word", 64'(d1), 64'(R4));
        tick;
        check("hold_after_pulse", 64'(d0), 64'(R5));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("accept2_data", 64'(d0), 64'(R6));
        check("accept2_beat", 64'(b0), 64'(2));
        check("u1_step4_word2", 64'(d1), 64'(R8));
        mode = 1'b1;
        tick;
        check("free_run_1", 64'(d0), 64'(R7));
        tick;
        check("free_run_2", 64'(d0), 64'(R8));
        check("free_run_beat", 64'(b0), 64'(2));
        mode = 1'b0;
        tick;
        check("freeze_1", 64'(d0), 64'(R8));
        tick;
        check("freeze_2", 64'(d0), 64'(R8));
        out_ready = 1'b1;
        repeat (15) tick;
        check("beat_17", 64'(b0), 64'(17));
        check("beat_wrap4", 64'(b2), 64'(1));
        seed_in = 32'h0;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        out_ready = 1'b0;
        check("seed_accept_beat", 64'(b0), 64'(18));
        check("seed_accept_wrap", 64'(b2), 64'(2));
        check("zero_seed_lockup", 64'(l0), 64'(1'b1));
        check("zero_seed_data", 64'(d0), 64'(SEED));
        check("reseed_valid_low0", 64'(v0), 64'(1'b0));
        check("u1_zero_lockup", 64'(l1), 64'(1'b1));
        check("u1_reseed_valid", 64'(v1), 64'(1'b0));
        repeat (3) begin
            tick;
            check("reseed_valid_low", 64'(v0), 64'(1'b0));
        end
        for (int i = 0; i < 8 && v0 !== 1'b1; i++) tick;
        check("reseed_valid", 64'(v0), 64'(1'b1));
        check("reseed_word", 64'(d0), 64'(R4));
        check("lockup_sticky", 64'(l0), 64'(1'b1));
        seed_in = 32'h1;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        check("lockup_cleared", 64'(l0), 64'(1'b0));
        check("seed1_data", 64'(d0), 64'(32'h1));
        check("seed1_valid_low", 64'(v0), 64'(1'b0));
        for (int i = 0; i < 8 && v0 !== 1'b1; i++) tick;
        check("seed1_valid", 64'(v0), 64'(1'b1));
        check("seed1_word", 64'(d0), 64'(32'h1B));
        out_ready = 1'b1;
        repeat (2) tick;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(v0), 64'(1'b0));
        check("async_rst_data", 64'(d0), 64'(SEED));
        check("async_rst_beat", 64'(b0), 64'(0));
        check("async_rst_lockup", 64'(l0), 64'(1'b0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
